// File: rtl/wrapper.sv
// UART program loader: 8N1 receiver assembles little-endian 32-bit words into
// instruction memory, then hands GPIO outputs to the synchronized inputs.
//
// Receiver states
//   state | meaning
//   IDLE  | line idle, waiting for a synchronized low
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sampling 8 data bits at bit centres, LSB first
//   STOP  | sampling the stop bit: valid byte, BREAK, or discard
module wrapper #(
    parameter int CLK_HZ    = 50000000,
    parameter int BIT_RATE  = 9600,
    parameter int MEM_WORDS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data,
    input  logic [3:0] input_gpio_pins,
    output logic [3:0] output_gpio_pins,
    output logic       write_done
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW             = $clog2(CYCLES_PER_BIT);
    localparam int AW             = $clog2(MEM_WORDS);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Synchronizers reset to the idle level of each line
    logic       rxd_s1, rxd_s2;
    logic [3:0] gpio_s1, gpio_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1  <= 1'b1;
            rxd_s2  <= 1'b1;
            gpio_s1 <= 4'b0000;
            gpio_s2 <= 4'b0000;
        end else begin
            rxd_s1  <= uart_rxd;
            rxd_s2  <= rxd_s1;
            gpio_s1 <= input_gpio_pins;
            gpio_s2 <= gpio_s1;
        end
    end

    rx_state_t       state, state_n;
    logic [CW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      data_n;
    logic            valid_n, brk_n;
    logic            tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= 3'd0;
            shreg         <= 8'h00;
            uart_rx_data  <= 8'h00;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            bit_idx       <= bit_idx_n;
            shreg         <= shreg_n;
            uart_rx_data  <= data_n;
            uart_rx_valid <= valid_n;
            uart_rx_break <= brk_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = uart_rx_data;
        valid_n   = 1'b0;
        brk_n     = 1'b0;
        tick      = (timer == '0);

        if (!uart_rx_en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s2) begin
                        state_n = START;
                        timer_n = HALF_LOAD;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxd_s2) begin
                            state_n   = DATA;
                            timer_n   = BIT_LOAD;
                            bit_idx_n = 3'd0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        timer_n = timer - CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_n = {rxd_s2, shreg[7:1]};
                        timer_n = BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end else begin
                        timer_n = timer - CW'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_n = IDLE;
                        if (rxd_s2) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end else if (shreg == 8'h00) begin
                            brk_n = 1'b1;
                        end
                    end else begin
                        timer_n = timer - CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Loader: bytes accumulate little-endian; the 4th byte completes the word
    logic [31:0]   imem [MEM_WORDS];
    logic [AW-1:0] addr;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_buf;
    logic [31:0]   full_word;
    logic          take_byte, word_end, mem_we;

    assign take_byte = uart_rx_valid && !write_done;
    assign word_end  = take_byte && (byte_cnt == 2'd3);
    assign full_word = {uart_rx_data, word_buf};
    assign mem_we    = word_end && (full_word != 32'hFFFF_FFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'h000000;
            write_done <= 1'b0;
        end else if (take_byte) begin
            case (byte_cnt)
                2'd0:    word_buf[7:0]   <= uart_rx_data;
                2'd1:    word_buf[15:8]  <= uart_rx_data;
                2'd2:    word_buf[23:16] <= uart_rx_data;
                default: word_buf        <= word_buf;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            if (word_end) begin
                if (!mem_we) begin
                    write_done <= 1'b1;
                end else if (addr == LAST_ADDR) begin
                    write_done <= 1'b1;
                end else begin
                    addr <= addr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            imem[addr] <= full_word;
        end
    end

    assign output_gpio_pins = write_done ? gpio_s2 : 4'b0000;

endmodule

// File: tb/tb_wrapper.sv
// Directed bench for the UART program loader, run with 16 clocks per bit
// and a 4-word memory so frames and the full-memory case stay short.
module tb_wrapper;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic [3:0] input_gpio_pins;
    logic [3:0] output_gpio_pins;
    logic       write_done;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int brk_cnt = 0;
    int both_cnt = 0;
    int v0, b0;

    always #5 clk = ~clk;

    wrapper #(
        .CLK_HZ   (160000),
        .BIT_RATE (10000),
        .MEM_WORDS(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_rxd        (uart_rxd),
        .uart_rx_en      (uart_rx_en),
        .uart_rx_break   (uart_rx_break),
        .uart_rx_valid   (uart_rx_valid),
        .uart_rx_data    (uart_rx_data),
        .input_gpio_pins (input_gpio_pins),
        .output_gpio_pins(output_gpio_pins),
        .write_done      (write_done)
    );

    always @(negedge clk) begin
        if (uart_rx_valid) valid_cnt++;
        if (uart_rx_break) brk_cnt++;
        if (uart_rx_valid && uart_rx_break) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            cycles(CPB);
        end
        uart_rxd = 1'b1;
        cycles(4);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send_frame(tmp[7:0], 1'b1);
        end
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2);
    endtask

    initial begin
        rst = 1'b1;
        uart_rxd = 1'b1;
        uart_rx_en = 1'b1;
        input_gpio_pins = 4'b0111;
        cycles(400);
        check("rst_data", {24'h0, uart_rx_data}, 32'h0);
        check("rst_valid", {31'h0, uart_rx_valid}, 32'h0);
        check("rst_done", {31'h0, write_done}, 32'h0);
        check("rst_gpio", {28'h0, output_gpio_pins}, 32'h0);

        rst = 1'b0;
        input_gpio_pins = 4'b1111;
        cycles(10000);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_done", {31'h0, write_done}, 32'h0);
        check("idle_gpio", {28'h0, output_gpio_pins}, 32'h0);

        // Four bytes forming one instruction word
        send_frame(8'h13, 1'b1);
        check("byte0_data", {24'h0, uart_rx_data}, 32'h13);
        send_frame(8'h01, 1'b1);
        check("byte1_data", {24'h0, uart_rx_data}, 32'h01);
        send_frame(8'h01, 1'b1);
        check("byte2_data", {24'h0, uart_rx_data}, 32'h01);
        send_frame(8'hFC, 1'b1);
        check("byte3_data", {24'h0, uart_rx_data}, 32'hFC);
        check("word_valid_cnt", valid_cnt, 4);
        check("word_imem0", dut.imem[0], 32'hFC010113);
        check("word_addr", {30'h0, dut.addr}, 32'd1);
        check("word_done", {31'h0, write_done}, 32'h0);

        // Reset in the middle of a word
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        pulse_reset();
        check("midrst_data", {24'h0, uart_rx_data}, 32'h0);
        check("midrst_addr", {30'h0, dut.addr}, 32'd0);
        send_word(32'h00001237);
        check("midrst_imem0", dut.imem[0], 32'h00001237);
        check("midrst_addr1", {30'h0, dut.addr}, 32'd1);

        // BREAK and framing error
        send_frame(8'h5A, 1'b1);
        check("pre_brk_data", {24'h0, uart_rx_data}, 32'h5A);
        v0 = valid_cnt;
        b0 = brk_cnt;
        uart_rxd = 1'b0;
        cycles(10 * CPB);
        uart_rxd = 1'b1;
        cycles(3 * CPB);
        check("brk_cnt", brk_cnt - b0, 1);
        check("brk_no_valid", valid_cnt - v0, 0);
        check("brk_data", {24'h0, uart_rx_data}, 32'h5A);
        send_frame(8'h81, 1'b0);
        cycles(2 * CPB);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_no_brk", brk_cnt - b0, 1);
        check("ferr_data", {24'h0, uart_rx_data}, 32'h5A);

        // Short glitch, then a whole frame with the receiver disabled
        uart_rxd = 1'b0;
        cycles(3);
        uart_rxd = 1'b1;
        cycles(2 * CPB);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_brk", brk_cnt - b0, 1);
        uart_rx_en = 1'b0;
        send_frame(8'h77, 1'b1);
        uart_rx_en = 1'b1;
        cycles(4);
        check("dis_valid", valid_cnt - v0, 0);
        check("dis_data", {24'h0, uart_rx_data}, 32'h5A);
        check("dis_addr", {30'h0, dut.addr}, 32'd1);
        check("dis_bytecnt", {30'h0, dut.byte_cnt}, 32'd1);

        // Terminator word ends the load and releases GPIO
        pulse_reset();
        send_word(32'h00000013);
        check("term_pre_done", {31'h0, write_done}, 32'h0);
        send_word(32'hFFFFFFFF);
        check("term_imem0", dut.imem[0], 32'h00000013);
        check("term_addr", {30'h0, dut.addr}, 32'd1);
        check("term_done", {31'h0, write_done}, 32'h1);
        input_gpio_pins = 4'b1010;
        cycles(2);
        check("gpio_1010", {28'h0, output_gpio_pins}, 32'hA);
        input_gpio_pins = 4'b0101;
        cycles(1);
        check("gpio_lat1", {28'h0, output_gpio_pins}, 32'hA);
        cycles(1);
        check("gpio_lat2", {28'h0, output_gpio_pins}, 32'h5);

        // After load, bytes still reach uart_rx_data but not the loader
        v0 = valid_cnt;
        send_frame(8'h42, 1'b1);
        check("post_valid", valid_cnt - v0, 1);
        check("post_data", {24'h0, uart_rx_data}, 32'h42);
        check("post_addr", {30'h0, dut.addr}, 32'd1);
        check("post_bytecnt", {30'h0, dut.byte_cnt}, 32'd0);

        // Filling the last location ends the load without wrapping
        pulse_reset();
        check("full_rst_done", {31'h0, write_done}, 32'h0);
        check("full_rst_gpio", {28'h0, output_gpio_pins}, 32'h0);
        send_word(32'h04030201);
        send_word(32'h14131211);
        send_word(32'h24232221);
        check("full_3w_done", {31'h0, write_done}, 32'h0);
        send_word(32'h34333231);
        check("full_done", {31'h0, write_done}, 32'h1);
        check("full_addr", {30'h0, dut.addr}, 32'd3);
        check("full_imem3", dut.imem[3], 32'h34333231);
        send_word(32'hDEADBEEF);
        check("full_imem0", dut.imem[0], 32'h04030201);
        check("full_imem3_keep", dut.imem[3], 32'h34333231);
        check("full_data", {24'h0, uart_rx_data}, 32'hDE);
        check("both_never", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wrapper.md
WRAPPER -- requirements
Module: wrapper

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600, UART bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (5208 at defaults).
REQ-003 Parameter MEM_WORDS, default 256, instruction-memory depth in 32-bit words (power of two).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 uart_rxd  input  1  UART receive line, 8N1, idle high, asynchronous to clk.
REQ-007 uart_rx_en  input  1  receiver enable.
REQ-008 uart_rx_break  output  1  one-cycle pulse: BREAK frame received.
REQ-009 uart_rx_valid  output  1  one-cycle pulse: valid byte received.
REQ-010 uart_rx_data  output  8  last valid received byte, held until next valid byte.
REQ-011 input_gpio_pins  input  4  asynchronous GPIO inputs.
REQ-012 output_gpio_pins  output  4  GPIO outputs.
REQ-013 write_done  output  1  high once program load is complete; sticky until reset.

Function
REQ-014 uart_rxd SHALL pass through a 2-flop synchronizer before any use; input_gpio_pins likewise, per bit.
REQ-015 Receiver states IDLE, START, DATA, STOP; in IDLE, a synchronized low moves to START.
REQ-016 START: wait CYCLES_PER_BIT/2 cycles, resample; low -> DATA, high -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: sample every CYCLES_PER_BIT cycles at bit centre, 8 bits, LSB first, then STOP.
REQ-018 STOP: sample after CYCLES_PER_BIT; high -> update uart_rx_data, pulse uart_rx_valid 1 cycle; low with all data bits 0 -> pulse uart_rx_break, data unchanged; low otherwise -> discard; all cases return to IDLE.
REQ-019 uart_rx_en low SHALL force receiver to IDLE, abort any frame in progress, and suppress both pulses.
REQ-020 uart_rx_valid and uart_rx_break SHALL never be high in the same cycle.
REQ-021 Loader: each valid byte while write_done=0 is placed into a 32-bit word little-endian (1st byte bits 7:0 ... 4th byte bits 31:24), byte counter 0..3.
REQ-022 On the 4th byte: word 32'hFFFFFFFF -> not stored, write_done set next cycle; otherwise stored at imem[addr], addr incremented.
REQ-023 Storing into the last location (addr = MEM_WORDS-1) SHALL also set write_done; no wrap-around overwrite.
REQ-024 While write_done=1, received bytes still drive uart_rx_data/uart_rx_valid but SHALL NOT alter memory, addr or byte counter.
REQ-025 output_gpio_pins SHALL be 4'b0000 while write_done=0, and equal the synchronized input_gpio_pins (2-cycle latency) while write_done=1.

Reset
REQ-026 rst=1 at a clock edge SHALL set: receiver IDLE, uart_rx_data=8'h00, uart_rx_valid=0, uart_rx_break=0, byte counter=0, addr=0, write_done=0, output_gpio_pins=0, synchronizers to idle (uart_rxd stage 1, GPIO stage 0).
REQ-027 Reset asserted mid-frame or mid-word SHALL discard the partial frame/word; memory contents need not be cleared.

Verification
REQ-028 rst high 4000 ns, input_gpio_pins=4'b0111, then rst low, pins 4'b1111, no UART traffic for 100 us -> uart_rx_valid never pulses, write_done=0, output_gpio_pins=4'b0000.
REQ-029 Send 8N1 bytes 0x13,0x01,0x01,0xFC at 9600 baud -> four valid pulses, uart_rx_data matches each byte after its stop bit, imem[0]=32'hFC010113, addr=1.
REQ-030 Send word 0x00000013 then 0xFFFFFFFF -> imem[0]=32'h00000013, write_done=1, then output_gpio_pins follows input_gpio_pins (4'b1010 in -> 4'b1010 out within 2 cycles).
REQ-031 Line held low 10 bit times then high -> one uart_rx_break pulse, no uart_rx_valid, uart_rx_data unchanged.
REQ-032 Low pulse of 1000 ns on idle line -> no pulses; uart_rx_en=0 during a full frame -> no pulses, no memory write.
REQ-033 rst asserted after 2 bytes of a word, then 4 new bytes sent -> word built only from the 4 new bytes, stored at imem[0].
